darkroom_spi_word_rx: RTL

//  SPI slave that receives lighthouse sweep words from the darkroom tracker's SPI master
//  (sck/mosi/ss_n) on the host FPGA side.
//  - Oversamples the SPI pins in the clk domain and assembles 32-bit words, MSB first.
//  - Buffers complete words in a first-word-fall-through (FWFT) FIFO.
//  - Presents each word, split into sensor fields, on a valid/ready stream.

---
 rtl/darkroom_spi_word_rx.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/darkroom_spi_word_rx.sv
// SPI mode-0 slave that oversamples sck/mosi/ss_n, assembles 32-bit MSB-first words and
// streams them through an FWFT FIFO. Define DARKROOM_RX_TIMESTAMP_EN to store a per-word clk timestamp.
module darkroom_spi_word_rx #(
  parameter int FIFO_DEPTH = 16,
  parameter int WORD_BITS  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck,
  input  logic        mosi,
  input  logic        ss_n,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [8:0]  m_sensor_id,
  output logic        m_lighthouse,
  output logic        m_axis,
  output logic        m_sweep_valid,
  output logic [19:0] m_duration,
  output logic [31:0] m_timestamp,
  output logic        frame_err,
  output logic [15:0] overflow_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(WORD_BITS);
`ifdef DARKROOM_RX_TIMESTAMP_EN
  localparam int FW = WORD_BITS + 32;
`else
  localparam int FW = WORD_BITS;
`endif

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  // Pin synchronisers; ss_n syncs reset to the deselected level.
  logic sck_s1_q, sck_s2_q, sck_s3_q;
  logic mosi_s1_q, mosi_s2_q;
  logic ss_s1_q, ss_s2_q;
  logic sck_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_s1_q  <= 1'b0;
      sck_s2_q  <= 1'b0;
      sck_s3_q  <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      ss_s1_q   <= 1'b1;
      ss_s2_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value, so the chain really is 3 stages.
      sck_s1_q  <= sck;
      sck_s2_q  <= sck_s1_q;
      sck_s3_q  <= sck_s2_q;
      mosi_s1_q <= mosi;
      mosi_s2_q <= mosi_s1_q;
      ss_s1_q   <= ss_n;
      ss_s2_q   <= ss_s1_q;
    end
  end

  assign sck_rise = sck_s2_q & ~sck_s3_q;

  state_t                 state_q, state_d;
  logic [WORD_BITS-1:0]   shreg_q, shreg_d;
  logic [BW-1:0]          bitcnt_q, bitcnt_d;
  logic                   word_done_q, word_done_d;
  logic                   frame_err_q, frame_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!ss_s2_q) state_d = ST_SHIFT;
      ST_SHIFT: if (ss_s2_q)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ss_n deassertion takes priority over a coincident sck edge; that bit is lost.
  always_comb begin
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    word_done_d = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: bitcnt_d = '0;
      ST_SHIFT: begin
        if (ss_s2_q) begin
          frame_err_d = (bitcnt_q != '0);
          bitcnt_d    = '0;
        end else if (sck_rise) begin
          shreg_d     = {shreg_q[WORD_BITS-2:0], mosi_s2_q};
          bitcnt_d    = bitcnt_q + BW'(1);
          word_done_d = (bitcnt_q == BW'(WORD_BITS - 1));
        end
      end
      default: bitcnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      word_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      word_done_q <= word_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;

  logic [FW-1:0] push_data;
`ifdef DARKROOM_RX_TIMESTAMP_EN
  logic [31:0] ts_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 32'd1;
  end
  assign push_data = {ts_q, shreg_q};
`else
  assign push_data = shreg_q;
`endif

  logic [FW-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [15:0]   overflow_q;
  logic          empty, full, pop, push_ok, drop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = !empty && m_ready;
  assign push_ok = word_done_q && (!full || pop);
  assign drop    = word_done_q && full && !pop;

  // NOTE: storage has no reset; outputs are gated by m_valid so stale contents never show.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      if (drop && overflow_q != 16'hFFFF) overflow_q <= overflow_q + 16'd1;
    end
  end

  logic [FW-1:0]        head;
  logic [WORD_BITS-1:0] word_out;

  assign head          = mem_q[rd_ptr_q[AW-1:0]];
  assign m_valid       = !empty;
  assign word_out      = m_valid ? head[WORD_BITS-1:0] : '0;
  assign m_sensor_id   = word_out[31:23];
  assign m_lighthouse  = word_out[22];
  assign m_axis        = word_out[21];
  assign m_sweep_valid = word_out[20];
  assign m_duration    = word_out[19:0];
  assign overflow_cnt  = overflow_q;
`ifdef DARKROOM_RX_TIMESTAMP_EN
  assign m_timestamp   = m_valid ? head[FW-1 -: 32] : 32'd0;
`else
  assign m_timestamp   = 32'd0;
`endif

endmodule
